// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: state encoding,
// line geometry and the latency counter width.
package data_mem_ctrl_pkg;

   localparam int PKG_WORD_W = 32;
   localparam int PKG_LINE_W = 128;
   localparam int LINE_WORDS = PKG_LINE_W / PKG_WORD_W;
   localparam int BEAT_W     = $clog2(LINE_WORDS);
   localparam int LAT_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_BURST = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // True on the beat that transfers the final word of a line.
   function automatic logic is_last_beat(input logic [BEAT_W-1:0] beat);
      return beat == BEAT_W'(LINE_WORDS - 1);
   endfunction

endpackage

// File: rtl/data_mem_ctrl_dmem_array.sv
// Single-port word RAM: synchronous write, combinational read on the same
// address. Contents are deliberately not reset.
module dmem_array #(
   parameter int ADDR_W = 10,
   parameter int WORD_W = 32,
   parameter int DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Backing data memory controller: word writes and 4-word line-fill reads
// with a modelled main-memory latency and a one-cycle completion pulse.
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int WORD_W  = PKG_WORD_W,
   parameter int LINE_W  = PKG_LINE_W,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              ready,
   output logic [LINE_W-1:0] rdata,
   output logic              busy
);

   // Handshake: a request is taken on the rising edge where req_valid and
   // req_ready are both high; req_ready is high only while IDLE, so requests
   // seen while busy are dropped, never queued, and the caller holds them.

   state_e              state_q, state_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [WORD_W-1:0]   wdata_q, wdata_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic [LINE_W-1:0]   rdata_q, rdata_d;
   logic                ready_q, ready_d;
   logic                req_ready_q, req_ready_d;
   logic                busy_q, busy_d;

   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [WORD_W-1:0]   mem_rdata;

   dmem_array #(
      .ADDR_W (ADDR_W),
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH)
   ) u_dmem_array (
      .clk   (clk),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (wdata_q),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      lat_d    = lat_q;
      beat_d   = beat_q;
      line_d   = line_q;
      rdata_d  = rdata_q;
      mem_we   = 1'b0;
      mem_addr = addr_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               lat_d   = LAT_W'(LATENCY - 1);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (lat_q == '0) begin
               if (we_q) begin
                  // Gated by reset so an aborted write never reaches the array.
                  mem_we  = ~reset;
                  state_d = ST_DONE;
               end else begin
                  beat_d  = '0;
                  state_d = ST_BURST;
               end
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         ST_BURST: begin
            // Line-aligned base plus beat: a burst stays within its own line.
            mem_addr = {addr_q[ADDR_W-1:BEAT_W], beat_q};
            line_d[WORD_W*beat_q +: WORD_W] = mem_rdata;
            beat_d = beat_q + 1'b1;
            if (is_last_beat(beat_q)) begin
               rdata_d = line_d;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ready_d     = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
      req_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         lat_q       <= '0;
         beat_q      <= '0;
         line_q      <= '0;
         rdata_q     <= '0;
         ready_q     <= 1'b0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         lat_q       <= lat_d;
         beat_q      <= beat_d;
         line_q      <= line_d;
         rdata_q     <= rdata_d;
         ready_q     <= ready_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign req_ready = req_ready_q;
   assign ready     = ready_q;
   assign rdata     = rdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances at LATENCY 4, 1 and 15 driven by
// shared tasks, with a scoreboard of expected lines and latencies.
module tb_data_mem_ctrl;

   localparam int N_DUT = 3;

   function automatic int lat_of(input int i);
      case (i)
         0:       return 4;
         1:       return 1;
         default: return 15;
      endcase
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic         req_valid [N_DUT];
   logic         req_we    [N_DUT];
   logic [9:0]   req_addr  [N_DUT];
   logic [31:0]  req_wdata [N_DUT];
   logic         req_ready [N_DUT];
   logic         ready     [N_DUT];
   logic [127:0] rdata     [N_DUT];
   logic         busy      [N_DUT];

   generate
      for (genvar g = 0; g < N_DUT; g++) begin : gen_dut
         data_mem_ctrl #(
            .ADDR_W  (10),
            .WORD_W  (32),
            .LINE_W  (128),
            .DEPTH   (1024),
            .LATENCY (lat_of(g))
         ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_ready (req_ready[g]),
            .ready     (ready[g]),
            .rdata     (rdata[g]),
            .busy      (busy[g])
         );
      end
   endgenerate

   logic [127:0] exp_q  [$];
   logic [127:0] mask_q [$];
   int           lat_q  [$];

   logic [31:0]  model_mem [N_DUT][1024];
   bit           model_vld [N_DUT][1024];
   logic [127:0] last_line [N_DUT];
   logic [127:0] last_mask [N_DUT];

   int n_chk = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_rdata_model();
      for (int i = 0; i < N_DUT; i++) begin
         last_line[i] = '0;
         last_mask[i] = '1;
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
   task automatic do_access(input int i, input bit we, input logic [9:0] addr,
                            input logic [31:0] wd, input bit intrude);
      logic [9:0]   base;
      logic [127:0] line, mask, exp_line, exp_mask;
      int           exp_lat, got_lat;
      bit           found;
      check("req_ready_pre", 128'(req_ready[i]), 128'(1));
      req_valid[i] = 1'b1;
      req_we[i]    = we;
      req_addr[i]  = addr;
      req_wdata[i] = wd;
      if (we) begin
         model_mem[i][addr] = wd;
         model_vld[i][addr] = 1'b1;
         exp_q.push_back(last_line[i]);
         mask_q.push_back(last_mask[i]);
         lat_q.push_back(lat_of(i));
      end else begin
         base = {addr[9:2], 2'b00};
         line = '0;
         mask = '0;
         for (int w = 0; w < 4; w++) begin
            if (model_vld[i][base + 10'(w)]) begin
               line[32*w +: 32] = model_mem[i][base + 10'(w)];
               mask[32*w +: 32] = '1;
            end
         end
         exp_q.push_back(line);
         mask_q.push_back(mask);
         lat_q.push_back(lat_of(i) + 4);
         last_line[i] = line;
         last_mask[i] = mask;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid[i] = 1'b0;
      req_we[i]    = ~we;
      req_addr[i]  = 10'($urandom);
      req_wdata[i] = $urandom;
      found   = 1'b0;
      got_lat = 0;
      for (int c = 1; c <= 40 && !found; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c == 1) begin
            check("busy_in_flight", 128'(busy[i]), 128'(1));
            check("req_ready_in_flight", 128'(req_ready[i]), 128'(0));
         end
         if (intrude && c == 1) begin
            req_valid[i] = 1'b1;
            req_we[i]    = 1'b1;
            req_addr[i]  = 10'h010;
            req_wdata[i] = 32'hAAAA0000;
         end
         if (intrude && c == 2) req_valid[i] = 1'b0;
         if (ready[i]) begin
            found   = 1'b1;
            got_lat = c;
         end
      end
      exp_line = exp_q.pop_front();
      exp_mask = mask_q.pop_front();
      exp_lat  = lat_q.pop_front();
      if (!found) begin
         check("ready_timeout", 128'(0), 128'(1));
      end else begin
         check("latency", 128'(got_lat), 128'(exp_lat));
         check("rdata", rdata[i] & exp_mask, exp_line);
      end
      @(posedge clk);
      @(negedge clk);
      check("ready_width", 128'(ready[i]), 128'(0));
      check("busy_after", 128'(busy[i]), 128'(0));
      check("req_ready_after", 128'(req_ready[i]), 128'(1));
   endtask

   initial begin
      #2_000_000;
      n_bad++;
      $display("FAIL watchdog expired t=%0t", $time);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      bit          seen;
      logic [9:0]  ra;
      logic [31:0] rd;
      reset = 1'b1;
      for (int i = 0; i < N_DUT; i++) begin
         req_valid[i] = 1'b0;
         req_we[i]    = 1'b0;
         req_addr[i]  = '0;
         req_wdata[i] = '0;
         for (int a = 0; a < 1024; a++) begin
            model_mem[i][a] = '0;
            model_vld[i][a] = 1'b0;
         end
      end
      clear_rdata_model();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Idle after reset
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
         for (int i = 0; i < N_DUT; i++) begin
            check("idle_req_ready", 128'(req_ready[i]), 128'(1));
            check("idle_ready", 128'(ready[i]), 128'(0));
            check("idle_busy", 128'(busy[i]), 128'(0));
            check("idle_rdata", rdata[i], 128'(0));
         end
      end

      // Write then read within the same line
      do_access(0, 1'b1, 10'h005, 32'hDEADBEEF, 1'b0);
      do_access(0, 1'b0, 10'h006, 32'h0, 1'b0);

      // Top-of-memory line fill, no wrap to address 0
      do_access(0, 1'b1, 10'h3FC, 32'h11111111, 1'b0);
      do_access(0, 1'b1, 10'h3FD, 32'h22222222, 1'b0);
      do_access(0, 1'b1, 10'h3FE, 32'h33333333, 1'b0);
      do_access(0, 1'b1, 10'h3FF, 32'h44444444, 1'b0);
      do_access(0, 1'b1, 10'h000, 32'h99999999, 1'b0);
      do_access(0, 1'b0, 10'h3FE, 32'h0, 1'b0);
      check("line_fill_literal", rdata[0], 128'h44444444_33333333_22222222_11111111);

      // Write request offered while a read sits in WAIT is ignored
      do_access(0, 1'b1, 10'h010, 32'h55555555, 1'b0);
      do_access(0, 1'b0, 10'h3FC, 32'h0, 1'b1);
      do_access(0, 1'b0, 10'h011, 32'h0, 1'b0);

      // Reset two edges into a write aborts it
      do_access(0, 1'b1, 10'h020, 32'h0BADF00D, 1'b0);
      check("abort_req_ready_pre", 128'(req_ready[0]), 128'(1));
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b1;
      req_addr[0]  = 10'h020;
      req_wdata[0] = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      clear_rdata_model();
      check("abort_busy", 128'(busy[0]), 128'(0));
      check("abort_req_ready", 128'(req_ready[0]), 128'(1));
      check("abort_ready", 128'(ready[0]), 128'(0));
      check("abort_rdata", rdata[0], 128'(0));
      seen = 1'b0;
      repeat (20) begin
         @(posedge clk);
         @(negedge clk);
         if (ready[0]) seen = 1'b1;
      end
      check("abort_no_ready", 128'(seen), 128'(0));
      do_access(0, 1'b0, 10'h020, 32'h0, 1'b0);

      // Reset and request in the same cycle: reset wins
      reset        = 1'b1;
      req_valid[1] = 1'b1;
      req_we[1]    = 1'b1;
      req_addr[1]  = 10'h030;
      req_wdata[1] = $urandom;
      @(posedge clk);
      @(negedge clk);
      reset        = 1'b0;
      req_valid[1] = 1'b0;
      clear_rdata_model();
      check("rst_win_busy", 128'(busy[1]), 128'(0));
      check("rst_win_req_ready", 128'(req_ready[1]), 128'(1));

      // Latency sweep on the LATENCY=1 and LATENCY=15 instances
      for (int i = 1; i < N_DUT; i++) begin
         for (int w = 0; w < 4; w++) begin
            do_access(i, 1'b1, 10'h3FC + 10'(w), $urandom, 1'b0);
         end
         do_access(i, 1'b0, 10'h3FD, 32'h0, 1'b0);
         ra = 10'($urandom_range(0, 1023));
         rd = $urandom;
         do_access(i, 1'b1, ra, rd, 1'b0);
         do_access(i, 1'b0, ra, 32'h0, 1'b0);
      end

      // Random mix on a small address window
      for (int k = 0; k < 12; k++) begin
         ra = 10'($urandom_range(64, 79));
         do_access(0, 1'($urandom_range(0, 1)), ra, $urandom, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Backing data memory plus controller, directly downstream of the data-cache controller.
- Accepts single-word write-through/write-around stores and 128-bit line-fill reads.
- Models multi-cycle main-memory latency and returns a one-cycle `ready` pulse when each access completes.
- The cache holds `stall` while waiting for that pulse.

Parameters:
- ADDR_W, 10, word address width
- WORD_W, 32, memory word width
- LINE_W, 128, cache line width (LINE_W/WORD_W = 4 words per line)
- DEPTH, 1024, number of memory words
- LATENCY, 4, access latency in cycles before data transfer; legal range 1..15

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_we  input  1  1 = word write, 0 = line read
- req_addr  input  ADDR_W  word address
- req_wdata  input  WORD_W  write data
- req_ready  output  1  controller idle; request accepted on the edge where req_valid && req_ready
- ready  output  1  one-cycle completion pulse to the cache controller
- rdata  output  LINE_W  line returned by the last completed read
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset is synchronous and active-high.
  - Reset values: state=IDLE, req_ready=1, ready=0, rdata=0, busy=0, counters=0.
  - The memory array is never cleared by reset.
  - Reset mid-operation aborts the access. A pending write that has not yet committed is discarded.
- States: IDLE, WAIT, BURST, DONE.
- IDLE:
  - req_ready=1.
  - On acceptance, latch we, addr and wdata; load lat_cnt=LATENCY-1; go to WAIT.
- WAIT:
  - Stays exactly LATENCY cycles, decrementing lat_cnt.
  - When lat_cnt==0:
    - Write: commit mem[addr]=wdata on that edge; go to DONE.
    - Read: load beat=0; go to BURST.
- BURST (reads only):
  - base = addr with bits [1:0] cleared (line-aligned).
  - Each cycle, copy mem[base+beat] into a line buffer slice [WORD_W*beat +: WORD_W], then increment beat.
  - After beat 3, go to DONE.
  - Line is little-endian by word: word 0 in bits [31:0].
  - Base is always aligned, so a burst never wraps (e.g. addr 1022 reads 1020..1023).
- DONE:
  - ready=1 for exactly one cycle.
  - For reads, rdata updates to the line buffer on the edge entering DONE and holds until the next read completes. Writes never change rdata.
  - Returns to IDLE on the next edge.
- Latency, with acceptance edge = E0:
  - Write: ready high in the cycle after edge E0+LATENCY.
  - Read: ready high in the cycle after edge E0+LATENCY+4.
  - Next request can be accepted on the edge after DONE.
- Requests arriving while busy:
  - req_ready=0, so they are ignored, not queued.
  - The upstream cache must hold req_valid and its fields stable until acceptance.
  - Latched fields are immune to upstream changes after acceptance.
- Simultaneous reset and req_valid: reset wins and the request is not accepted.
- Address range: all ADDR_W values are legal; DEPTH must equal 2**ADDR_W.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, WAIT=1, BURST=2, DONE=3)
  - LINE_WORDS = LINE_W/WORD_W
  - BEAT_W = clog2(LINE_WORDS)
  - LAT_W = 4
- One sub-module, dmem_array: single-port word RAM (DEPTH x WORD_W) with synchronous write and combinational read.
  - The controller FSM drives its address mux (latched addr for write, base+beat for burst) and write enable.

Test Plan:
- Reset, then idle: no requests -> req_ready=1, ready=0, busy=0, rdata=0 for 10 cycles.
- Write then read: write 0xDEADBEEF to addr 0x005 with LATENCY=4 -> ready pulses in the cycle after edge E0+4. Then read addr 0x006 -> ready in the cycle after edge E0+8, rdata[63:32]=0xDEADBEEF.
- Full line fill: write 0x11111111, 0x22222222, 0x33333333, 0x44444444 to 0x3FC..0x3FF. Read addr 0x3FE -> rdata=0x44444444_33333333_22222222_11111111, no wrap to address 0.
- Busy rejection: while a read is in WAIT, pulse a write req to 0x010 with data 0xAAAA0000 -> req_ready=0, request ignored, mem[0x010] unchanged, rdata unaffected.
- Reset mid-write: accept a write to 0x020 with data 0x12345678, assert reset at E0+2 -> no ready pulse, mem[0x020] retains its prior value, state IDLE next cycle.
- Latency sweep: LATENCY=1 and LATENCY=15 -> write ready in the cycle after E0+1 and E0+15; read ready in the cycle after E0+5 and E0+19; ready is exactly one cycle wide in every case.
